// File: rtl/id_ex_reg.sv
// D->E pipeline register of the P7 five-stage MIPS core.
// Captures the decoded D-stage bundle into E. A hazard stall turns the E slot
// into a bubble that still carries the D-stage PC/BD, so an exception taken on
// the bubble reports a correct EPC. An exception/interrupt request flushes E
// to an empty slot tagged with the handler PC.
module id_ex_reg #(
  parameter logic [31:0] PC_INIT    = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        stall,
  input  logic [31:0] D_PC,
  input  logic [31:0] D_instr,
  input  logic [31:0] D_imm32,
  input  logic [31:0] D_lui,
  input  logic [31:0] D_rs_data,
  input  logic [31:0] D_rt_data,
  input  logic [4:0]  D_ExcCode,
  input  logic        D_BD,
  output logic [31:0] E_PC,
  output logic [31:0] E_instr,
  output logic [31:0] E_imm32,
  output logic [31:0] E_lui,
  output logic [31:0] E_rs_data,
  output logic [31:0] E_rt_data,
  output logic [4:0]  E_ExcCode,
  output logic        E_BD,
  output logic        E_bubble
);

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_imm32;
  logic [31:0] r_lui;
  logic [31:0] r_rs_data;
  logic [31:0] r_rt_data;
  logic [4:0]  r_exc_code;
  logic        r_bd;
  logic        r_bubble;

  // Load the E-stage slot every edge: reset > flush > bubble > normal load.
  // NOTE: reset is tested inside the clocked block, so it is synchronous and
  // only takes effect on a rising edge, like every other update here.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: non-blocking assignments keep every field sampling the same
      // pre-edge values, whatever order the statements appear in.
      r_pc       <= PC_INIT;
      r_instr    <= '0;
      r_imm32    <= '0;
      r_lui      <= '0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_exc_code <= '0;
      r_bd       <= 1'b0;
      r_bubble   <= 1'b1;
    end else if (Req) begin
      // Flush: the slot is empty and owned by the handler, so no BD/exception.
      r_pc       <= HANDLER_PC;
      r_instr    <= '0;
      r_imm32    <= '0;
      r_lui      <= '0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_exc_code <= '0;
      r_bd       <= 1'b0;
      r_bubble   <= 1'b1;
    end else if (stall) begin
      // Bubble: a nop that keeps D's PC/BD for precise EPC on a later trap.
      r_pc       <= D_PC;
      r_instr    <= '0;
      r_imm32    <= '0;
      r_lui      <= '0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_exc_code <= '0;
      r_bd       <= D_BD;
      r_bubble   <= 1'b1;
    end else begin
      // Normal advance; exception code is forwarded, never generated here.
      r_pc       <= D_PC;
      r_instr    <= D_instr;
      r_imm32    <= D_imm32;
      r_lui      <= D_lui;
      r_rs_data  <= D_rs_data;
      r_rt_data  <= D_rt_data;
      r_exc_code <= D_ExcCode;
      r_bd       <= D_BD;
      r_bubble   <= 1'b0;
    end
  end

  // Outputs come straight from the registers: no input-to-output path.
  assign E_PC      = r_pc;
  assign E_instr   = r_instr;
  assign E_imm32   = r_imm32;
  assign E_lui     = r_lui;
  assign E_rs_data = r_rs_data;
  assign E_rt_data = r_rt_data;
  assign E_ExcCode = r_exc_code;
  assign E_BD      = r_bd;
  assign E_bubble  = r_bubble;

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: each directed vector pushes its
// hand-computed E-stage image; a monitor pops one image after every edge.
module tb_id_ex_reg;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] imm32;
    logic [31:0] lui;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  exc;
    logic        bd;
    logic        bubble;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, Req, stall;
  logic [31:0] D_PC, D_instr, D_imm32, D_lui, D_rs_data, D_rt_data;
  logic [4:0]  D_ExcCode;
  logic        D_BD;
  logic [31:0] E_PC, E_instr, E_imm32, E_lui, E_rs_data, E_rt_data;
  logic [4:0]  E_ExcCode;
  logic        E_BD, E_bubble;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  id_ex_reg dut (
    .clk       (clk),
    .reset     (reset),
    .Req       (Req),
    .stall     (stall),
    .D_PC      (D_PC),
    .D_instr   (D_instr),
    .D_imm32   (D_imm32),
    .D_lui     (D_lui),
    .D_rs_data (D_rs_data),
    .D_rt_data (D_rt_data),
    .D_ExcCode (D_ExcCode),
    .D_BD      (D_BD),
    .E_PC      (E_PC),
    .E_instr   (E_instr),
    .E_imm32   (E_imm32),
    .E_lui     (E_lui),
    .E_rs_data (E_rs_data),
    .E_rt_data (E_rt_data),
    .E_ExcCode (E_ExcCode),
    .E_BD      (E_BD),
    .E_bubble  (E_bubble)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one registered E image appears after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".E_PC"},      E_PC,             e.pc);
        check({e.name, ".E_instr"},   E_instr,          e.instr);
        check({e.name, ".E_imm32"},   E_imm32,          e.imm32);
        check({e.name, ".E_lui"},     E_lui,            e.lui);
        check({e.name, ".E_rs_data"}, E_rs_data,        e.rs);
        check({e.name, ".E_rt_data"}, E_rt_data,        e.rt);
        check({e.name, ".E_ExcCode"}, {27'd0, E_ExcCode}, {27'd0, e.exc});
        check({e.name, ".E_BD"},      {31'd0, E_BD},     {31'd0, e.bd});
        check({e.name, ".E_bubble"},  {31'd0, E_bubble}, {31'd0, e.bubble});
      end
    end
  end

  task automatic set_d(input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] imm, input logic [31:0] lui,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic [4:0] exc, input logic bd);
    D_PC = pc; D_instr = instr; D_imm32 = imm; D_lui = lui;
    D_rs_data = rs; D_rt_data = rt; D_ExcCode = exc; D_BD = bd;
  endtask

  // Drive controls for one cycle and queue the E image expected after the edge.
  task automatic step(input logic r, input logic q, input logic s,
                      input string name, input logic [31:0] pc,
                      input logic [31:0] instr, input logic [31:0] imm,
                      input logic [31:0] lui, input logic [31:0] rs,
                      input logic [31:0] rt, input logic [4:0] exc,
                      input logic bd, input logic bub);
    exp_t e;
    reset = r; Req = q; stall = s;
    e.name = name; e.pc = pc; e.instr = instr; e.imm32 = imm; e.lui = lui;
    e.rs = rs; e.rt = rt; e.exc = exc; e.bd = bd; e.bubble = bub;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    // Reset for two cycles with random D inputs.
    set_d($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 5'd7, 1'b1);
    step(1, 0, 0, "reset0", 32'h0000_3000, 0, 0, 0, 0, 0, 5'd0, 0, 1);
    set_d($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 5'd12, 1'b1);
    step(1, 0, 1, "reset1", 32'h0000_3000, 0, 0, 0, 0, 0, 5'd0, 0, 1);

    // Normal load (lui).
    set_d(32'h0000_3004, 32'h3C01_1234, 32'h0000_1234, 32'h1234_0000,
          32'hA5A5_A5A5, 32'h5A5A_0001, 5'd0, 1'b0);
    step(0, 0, 0, "load_lui", 32'h0000_3004, 32'h3C01_1234, 32'h0000_1234,
         32'h1234_0000, 32'hA5A5_A5A5, 32'h5A5A_0001, 5'd0, 0, 0);

    // Back-to-back normal load with BD set.
    set_d(32'h0000_3008, 32'h0022_1820, 32'h0000_1820, 32'h1820_0000,
          32'h1111_1111, 32'h2222_2222, 5'd0, 1'b1);
    step(0, 0, 0, "load_bd", 32'h0000_3008, 32'h0022_1820, 32'h0000_1820,
         32'h1820_0000, 32'h1111_1111, 32'h2222_2222, 5'd0, 1, 0);

    // Three stalled cycles: bubbles carrying D_PC/D_BD, exception cleared.
    set_d(32'h0000_3010, 32'h8C22_0004, 32'h0000_0004, 32'h0004_0000,
          32'h0000_3000, 32'h0000_0077, 5'd6, 1'b1);
    step(0, 0, 1, "stall0", 32'h0000_3010, 0, 0, 0, 0, 0, 5'd0, 1, 1);
    step(0, 0, 1, "stall1", 32'h0000_3010, 0, 0, 0, 0, 0, 5'd0, 1, 1);
    step(0, 0, 1, "stall2", 32'h0000_3010, 0, 0, 0, 0, 0, 5'd0, 1, 1);
    // Release: the held D instruction enters E.
    step(0, 0, 0, "release", 32'h0000_3010, 32'h8C22_0004, 32'h0000_0004,
         32'h0004_0000, 32'h0000_3000, 32'h0000_0077, 5'd6, 1, 0);

    // Flush overriding stall.
    set_d(32'h0000_3014, 32'h1234_5678, 32'h0000_5678, 32'h5678_0000,
          32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd10, 1'b1);
    step(0, 1, 1, "flush_stall", 32'h0000_4180, 0, 0, 0, 0, 0, 5'd0, 0, 1);
    step(0, 1, 0, "flush_only", 32'h0000_4180, 0, 0, 0, 0, 0, 5'd0, 0, 1);

    // Exception code passthrough (AdEL on misaligned PC).
    set_d(32'h0000_3021, 32'h8C01_0000, 32'h0000_0000, 32'h0000_0000,
          32'h0000_0010, 32'h0000_0020, 5'd4, 1'b0);
    step(0, 0, 0, "exc_pass", 32'h0000_3021, 32'h8C01_0000, 0, 0,
         32'h0000_0010, 32'h0000_0020, 5'd4, 0, 0);

    // Reset beats Req and stall.
    set_d(32'h0000_3040, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_0000,
          32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 1'b1);
    step(1, 1, 1, "prio_all", 32'h0000_3000, 0, 0, 0, 0, 0, 5'd0, 0, 1);

    // Recovery: normal load right after reset.
    set_d(32'h0000_3044, 32'h2042_0001, 32'h0000_0001, 32'h0001_0000,
          32'h0000_00AB, 32'h0000_00CD, 5'd0, 1'b0);
    step(0, 0, 0, "recover", 32'h0000_3044, 32'h2042_0001, 32'h0000_0001,
         32'h0001_0000, 32'h0000_00AB, 32'h0000_00CD, 5'd0, 0, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- D→E pipeline register of the P7 five-stage MIPS core.
- Sits directly downstream of the immediate extender. Latches the D-stage PC, instruction, register-file read data, extended immediate (imm32), lui value, exception code and branch-delay flag into the E stage.
- Implements bubble insertion on hazard stall, and flushes on exception/interrupt request while preserving the PC and BD information CP0 needs for EPC.

Parameters:
- PC_INIT, 32'h0000_3000, PC value held after reset.
- HANDLER_PC, 32'h0000_4180, PC value loaded on Req flush.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Req  input  1  exception/interrupt flush request from CP0.
- stall  input  1  hazard-unit stall; D holds, E receives bubble.
- D_PC  input  32  PC of D-stage instruction.
- D_instr  input  32  D-stage instruction word.
- D_imm32  input  32  extended immediate from extender.
- D_lui  input  32  {imm16,16'b0} from extender.
- D_rs_data  input  32  forwarded rs read value.
- D_rt_data  input  32  forwarded rt read value.
- D_ExcCode  input  5  exception code detected at or before D (0 = none).
- D_BD  input  1  D instruction is in a branch delay slot.
- E_PC  output  32  latched PC.
- E_instr  output  32  latched instruction.
- E_imm32  output  32  latched imm32.
- E_lui  output  32  latched lui value.
- E_rs_data  output  32  latched rs value.
- E_rt_data  output  32  latched rt value.
- E_ExcCode  output  5  latched exception code.
- E_BD  output  1  latched delay-slot flag.
- E_bubble  output  1  1 when E holds an inserted bubble, not a real instruction.

Behaviour:
- Register update occurs only on the rising clk edge.
- Priority, highest first: reset > Req > stall > normal load.
- reset:
  - E_PC = PC_INIT.
  - E_instr, E_imm32, E_lui, E_rs_data, E_rt_data = 0.
  - E_ExcCode = 0, E_BD = 0, E_bubble = 1.
- Req (reset low):
  - E_PC = HANDLER_PC.
  - All data fields, E_ExcCode and E_BD = 0; E_bubble = 1.
  - Req overrides stall in the same cycle.
- stall (reset, Req low), bubble insertion:
  - E_instr, E_imm32, E_lui, E_rs_data, E_rt_data = 0 (nop); E_ExcCode = 0; E_bubble = 1.
  - E_PC = D_PC and E_BD = D_BD, so a later-stage exception or interrupt taken on the bubble reports the correct EPC/BD.
- Normal (all low):
  - Every E_* output takes its D_* counterpart; E_bubble = 0.
  - The exception code passes through unchanged; this block never originates an exception.
- Latency: exactly 1 cycle from D_* to E_* in normal mode. No combinational path from any input to any output.
- Consecutive stalls: each stalled cycle reloads a bubble carrying the current D_PC/D_BD. D_PC is stable during a stall because upstream holds.
- Stall released: the next edge loads the real D instruction with E_bubble = 0.
- reset asserted mid-stall or mid-Req: reset values win on that edge.
- Outputs are held only while clk has no edge. There is no enable other than the above, and the register never holds its old value across an edge.

Test Plan:
- Reset: reset = 1 for 2 cycles with random D inputs → E_PC = 0x0000_3000, all data 0, E_ExcCode = 0, E_BD = 0, E_bubble = 1.
- Normal load: D_PC = 0x3004, D_instr = 0x3C01_1234 (lui), D_lui = 0x1234_0000, D_imm32 = 0x0000_1234, D_rs_data = 0xA5A5_A5A5 → after one edge all E_* match, E_bubble = 0.
- Stall: D_PC = 0x3010, D_BD = 1, D_instr = 0x8C22_0004, stall = 1 for 3 cycles → each cycle E_instr = 0, E_imm32 = 0, E_ExcCode = 0, E_PC = 0x3010, E_BD = 1, E_bubble = 1. Release → E_instr = 0x8C22_0004, E_bubble = 0.
- Flush: Req = 1 with stall = 1 and D_ExcCode = 10 → E_PC = 0x0000_4180, E_ExcCode = 0, E_BD = 0, E_instr = 0, E_bubble = 1.
- Exception passthrough: D_ExcCode = 4, D_PC = 0x3021 (AdEL), stall = 0 → E_ExcCode = 4, E_PC = 0x3021.
- Priority: reset = 1, Req = 1, stall = 1 simultaneously → reset values, E_PC = 0x0000_3000 (not 0x4180).
